// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types for the iterative HI/LO multiply/divide unit.
//   muldiv_op_t    : operation encoding carried on the op_i port
//   muldiv_state_t : sequencing states of the unit
package mips_cpu_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_DIVU  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_MULT  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_NOP6  = 3'b110,
        OP_NOP7  = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_div_step.sv
// One restoring-division step (purely combinational).
//   rem_i     : current partial remainder (always < divisor)
//   bit_i     : next dividend bit shifted in
//   divisor_i : divisor magnitude
//   rem_o     : new partial remainder
//   q_o       : quotient bit produced by this step
module mips_cpu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    // The shifted remainder can reach 2*divisor-1, so it needs one extra bit;
    // the MSB of the difference then acts as the borrow / "negative" flag.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, divisor_i};
    assign q_o     = ~diff[WIDTH];
    assign rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/mips_cpu_muldiv_iter.sv
// Iterative HI/LO multiply/divide unit: WIDTH-cycle shift/add multiplier and
// restoring divider with a start/busy/done handshake, plus MTHI/MTLO writes.
//   clk, reset     : clock, synchronous active-high reset
//   start_i, op_i  : request and operation (see muldiv_op_t)
//   a_i, b_i       : operands (A also carries MTHI/MTLO data)
//   busy_o         : mult/div in progress
//   done_o         : one-cycle pulse when hi_o/lo_o hold a new result
//   hi_o, lo_o     : HI/LO registers
//
// state | meaning
// IDLE  | accepting start; MTHI/MTLO written here
// RUN   | WIDTH iterations of multiply or divide
// FIX   | sign correction, HI/LO write, done pulse
module mips_cpu_muldiv_iter
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             mul_q, mul_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             div0_q, div0_d;
    logic             done_q, done_d;

    logic               is_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               run_last;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;

    assign is_signed = op_i[1];
    assign abs_a     = (is_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign abs_b     = (is_signed && b_i[WIDTH-1]) ? -b_i : b_i;
    assign run_last  = (cnt_q == CNT_W'(WIDTH - 1));

    // Multiplier lives in acc_q[WIDTH-1:0] and is consumed LSB first while the
    // partial product grows in the upper half; the carry goes back into the MSB.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;

    // For divide, acc_q[WIDTH-1:0] shifts the dividend out MSB first and the
    // quotient in LSB first.
    mips_cpu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (rem_q),
        .bit_i     (acc_q[WIDTH-1]),
        .divisor_i (opb_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mul_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mul_q   <= mul_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            div0_q  <= div0_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i && !op_i[2]) state_d = RUN;
            RUN:     if (run_last) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = done_q;
        hi_o   = hi_q;
        lo_o   = lo_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mul_d   = mul_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        div0_d  = div0_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    case (op_i)
                        OP_MTHI: hi_d = a_i;
                        OP_MTLO: lo_d = a_i;
                        OP_DIVU, OP_DIV, OP_MULTU, OP_MULT: begin
                            mul_d   = op_i[0];
                            neg_a_d = is_signed & a_i[WIDTH-1];
                            neg_b_d = is_signed & b_i[WIDTH-1];
                            div0_d  = (b_i == '0);
                            cnt_d   = '0;
                            rem_d   = '0;
                            acc_d   = {{WIDTH{1'b0}}, op_i[0] ? abs_b : abs_a};
                            opb_d   = op_i[0] ? abs_a : abs_b;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mul_q) begin
                    acc_d = mul_next;
                end else begin
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], step_q};
                    rem_d = step_rem;
                end
            end
            FIX: begin
                done_d = 1'b1;
                if (mul_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else begin
                    // With a zero divisor every step keeps the shifted value, so
                    // the remainder ends up as |a| and its sign fix restores a.
                    hi_d = neg_a_q ? -rem_q : rem_q;
                    if (div0_q)
                        lo_d = '1;
                    else if (neg_a_q ^ neg_b_q)
                        lo_d = -acc_q[WIDTH-1:0];
                    else
                        lo_d = acc_q[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_cpu_muldiv_iter.sv
module tb_mips_cpu_muldiv_iter;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    // Transaction-level model state
    logic [31:0] m_hi, m_lo;
    logic        m_busy, m_done;
    logic [63:0] m_pend;
    int          m_left;

    mips_cpu_muldiv_iter #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // {hi, lo} for a mult/div op, from plain arithmetic.
    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int          sx, sy, q, r;
        longint      sp;
        logic [63:0] up;
        sx = x;
        sy = y;
        case (o)
            3'd3: begin sp = longint'(sx) * longint'(sy); return sp; end
            3'd1: begin up = {32'd0, x} * {32'd0, y}; return up; end
            3'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    {m_hi, m_lo} = m_pend;
                end
            end else if (start) begin
                case (op)
                    3'd4: m_hi = a;
                    3'd5: m_lo = a;
                    3'd6, 3'd7: ;
                    default: begin
                        m_pend = ref_res(op, a, b);
                        m_busy = 1;
                        m_left = WIDTH + 1;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
            chk("model_done", {31'd0, done}, {31'd0, m_done});
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
    end

    // Called at a negedge; leaves at the negedge after the start edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1; op = o; a = x; b = y;
        @(negedge clk);
        start = 0; op = 3'd0; a = $urandom; b = $urandom;
    endtask

    task automatic finish_op(input string name, input logic [31:0] eh, input logic [31:0] el, input bit chk_busy);
        int busy_cyc;
        bit ok;
        busy_cyc = 0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy) busy_cyc++;
            if (done) begin ok = 1; break; end
            @(negedge clk);
        end
        chk({name, "_done_seen"}, {31'd0, ok}, 32'd1);
        if (chk_busy) chk({name, "_busy_cycles"}, busy_cyc, 32'd33);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
    endtask

    initial begin
        int dcount;
        reset = 1; start = 0; op = 0; a = 0; b = 0;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        reset = 0;
        @(negedge clk);

        issue(3'd4, 32'hAAAA_5555, 32'd0);
        chk("mthi_hi", hi, 32'hAAAA_5555);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd5, 32'h0F0F_0F0F, 32'd0);
        chk("mtlo_lo", lo, 32'h0F0F_0F0F);
        chk("mtlo_hi", hi, 32'hAAAA_5555);
        chk("mtlo_done", {31'd0, done}, 32'd0);
        issue(3'd6, 32'h1111_2222, 32'd3);
        chk("nop_hi", hi, 32'hAAAA_5555);
        chk("nop_lo", lo, 32'h0F0F_0F0F);
        chk("nop_busy", {31'd0, busy}, 32'd0);

        issue(3'd3, 32'hFFFF_FFFD, 32'd5);
        finish_op("mult_neg3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1);
        @(negedge clk);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1);
        @(negedge clk);
        chk("multu_done_width", {31'd0, done}, 32'd0);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_neg7by2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1);
        @(negedge clk);

        issue(3'd0, 32'd100, 32'd7);
        finish_op("divu_100by7", 32'd2, 32'd14, 1);
        // accepted in the same cycle done is high
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_overflow", 32'd0, 32'h8000_0000, 1);
        @(negedge clk);

        issue(3'd0, 32'h0000_1234, 32'd0);
        finish_op("divu_by0", 32'h0000_1234, 32'hFFFF_FFFF, 1);
        @(negedge clk);

        issue(3'd2, 32'hFFFF_FF00, 32'd0);
        finish_op("div_by0", 32'hFFFF_FF00, 32'hFFFF_FFFF, 1);
        @(negedge clk);

        issue(3'd3, 32'd7, 32'hFFFF_FFFE);
        repeat (5) @(negedge clk);
        issue(3'd4, 32'hDEAD_BEEF, 32'd0);
        finish_op("mult_mthi_ignored", 32'hFFFF_FFFF, 32'hFFFF_FFF2, 0);
        @(negedge clk);

        issue(3'd4, 32'h11, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        issue(3'd1, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("rst_run_hi", hi, 32'd0);
        chk("rst_run_lo", lo, 32'd0);
        chk("rst_run_busy", {31'd0, busy}, 32'd0);
        dcount = 0;
        repeat (40) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk("rst_run_no_done", dcount, 32'd0);

        issue(3'd1, 32'd3, 32'd4);
        finish_op("multu_3x4", 32'd0, 32'd12, 1);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
